// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC and fetches one word per instruction over a
// valid/ready imem handshake. Define FETCH_ALIGN_CHK_EN to trap misaligned branch targets.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            core_ready,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic            func7
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef FETCH_ALIGN_CHK_EN
    ,
    S_HALT
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            req_valid_q, req_valid_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] pc_inc;
`ifdef FETCH_ALIGN_CHK_EN
  logic            fault_q, fault_d;
`endif

  assign pc_inc = pc_q + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_ALIGN_CHK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  // Handshake sequencing; the request/valid flags are registered copies of the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_ALIGN_CHK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_REQ: begin
        if (req_valid_q && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (core_ready) begin
`ifdef FETCH_ALIGN_CHK_EN
          if (pc_src && (pc_target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = pc_src ? pc_target : pc_inc;
            state_d = S_REQ;
          end
`else
          pc_d    = pc_src ? pc_target : pc_inc;
          state_d = S_REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHK_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase
    req_valid_d   = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_inc;
  assign op             = instr_q[6:0];
  assign func3          = instr_q[14:12];
  assign func7          = instr_q[30];
`ifdef FETCH_ALIGN_CHK_EN
  assign fetch_fault    = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: imem and core models on the falling edge.
// Fault checks compiled in when FETCH_ALIGN_CHK_EN is defined.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        core_ready, pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_fault;
`endif

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .core_ready     (core_ready),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .op             (op),
    .func3          (func3),
    .func7          (func7)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs = 0;
  int n_acc = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_delay = 0;
  int cnt = 0;

  // knobs written by the main sequence, read by the models
  logic        req_ready_en = 1'b0;
  logic        core_ready_en = 1'b0;
  logic        pc_src_k = 1'b0;
  logic [31:0] pc_target_k = 32'h0;
  int          rsp_delay = 0;

  // model state owned by the falling-edge process
  exp_t        sb[$];
  logic        pending = 1'b0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] last_acc_addr = 32'h0;
  logic [31:0] halt_pc = 32'h0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0020_8133;
    return {a[26:2], 7'h33};
  endfunction

  // imem and core models
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      core_ready     = 1'b0;
      pc_src         = 1'b0;
      pc_target      = 32'h0;
      pending        = 1'b0;
      sb.delete();
      model_pc       = RESET_PC;
      prev_valid     = 1'b0;
    end else begin
      if (pending) check("valid_in_wait", 32'(instr_valid), 32'd0);
      if (instr_valid && !prev_valid) check("latency", 32'(cyc - acc_cyc), 32'(2 + acc_delay));
      prev_valid = instr_valid;
      core_ready = core_ready_en;
      pc_src     = 1'b1;
      pc_target  = 32'hBAD0_0004;
      if (instr_valid && core_ready_en) begin
        pc_src    = pc_src_k;
        pc_target = pc_target_k;
        check("sb_depth", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("instr", instr, e.word);
          check("pc", pc, e.pc);
          check("op", 32'(op), 32'(e.word[6:0]));
          check("func3", 32'(func3), 32'(e.word[14:12]));
          check("func7", 32'(func7), 32'(e.word[30]));
          check("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
        n_hs++;
`ifdef FETCH_ALIGN_CHK_EN
        if (pc_src_k && (pc_target_k[1:0] != 2'b00)) halt_pc = model_pc;
        else model_pc = pc_src_k ? pc_target_k : model_pc + 32'd4;
`else
        model_pc = pc_src_k ? pc_target_k : model_pc + 32'd4;
`endif
      end
      if (pending) begin
        imem_rsp_data = 32'hDEAD_BEEF;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = pend_data;
          pending        = 1'b0;
        end else begin
          cnt--;
          imem_rsp_valid = 1'b0;
        end
      end else begin
        // stray responses outside WAIT must be ignored
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      imem_req_ready = req_ready_en;
      if (imem_req_valid && req_ready_en) begin
        check("req_addr", imem_addr, model_pc);
        e.pc   = model_pc;
        e.word = mem_word(model_pc);
        sb.push_back(e);
        pend_data     = e.word;
        pending       = 1'b1;
        cnt           = rsp_delay;
        acc_cyc       = cyc;
        acc_delay     = rsp_delay;
        last_acc_addr = imem_addr;
        n_acc++;
      end
    end
  end

  task automatic wait_hs(input int tgt);
    int k = 0;
    while (n_hs < tgt && k < 200) begin @(posedge clk); #2; k++; end
    check("wait_hs", 32'(n_hs >= tgt), 32'd1);
  endtask

  task automatic wait_acc(input int tgt);
    int k = 0;
    while (n_acc < tgt && k < 200) begin @(posedge clk); #2; k++; end
    check("wait_acc", 32'(n_acc >= tgt), 32'd1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!instr_valid && k < 200) begin @(posedge clk); #2; k++; end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_pending();
    int k = 0;
    while (!pending && k < 200) begin @(posedge clk); #2; k++; end
    check("wait_pending", 32'(pending), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, a;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    core_ready = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    rsp_delay = 2;
    #3;
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_op", 32'(op), 32'h13);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
`ifdef FETCH_ALIGN_CHK_EN
    check("rst_fault", 32'(fetch_fault), 32'd0);
`endif
    @(posedge clk); #2;
    rst = 1'b0;

    // request backpressure then delayed response
    repeat (3) begin
      @(posedge clk); #2;
      check("req_held", 32'(imem_req_valid), 32'd1);
      check("no_valid_stall", 32'(instr_valid), 32'd0);
    end
    check("no_acc_stall", 32'(n_acc), 32'd0);
    req_ready_en = 1'b1;
    wait_valid();
    check("single_req", 32'(n_acc), 32'd1);

    // core stall in HOLD
    repeat (5) begin
      @(posedge clk); #2;
      check("hold_instr", instr, 32'h0000_0013);
      check("hold_pc", pc, 32'h0);
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    rsp_delay = 0;
    core_ready_en = 1'b1;
    @(posedge clk); #2;
    check("valid_fall", 32'(instr_valid), 32'd0);
    check("pc_adv", pc, 32'h4);
    wait_hs(2);

    // taken branch, then wrap-around
    pc_src_k = 1'b1; pc_target_k = 32'h100;
    h = n_hs; wait_hs(h + 1); pc_src_k = 1'b0;
    a = n_acc; wait_acc(a + 1);
    check("branch_addr", last_acc_addr, 32'h100);
    pc_src_k = 1'b1; pc_target_k = 32'hFFFF_FFFC;
    h = n_hs; wait_hs(h + 1); pc_src_k = 1'b0;
    a = n_acc; wait_acc(a + 1);
    check("top_addr", last_acc_addr, 32'hFFFF_FFFC);
    a = n_acc; wait_acc(a + 1);
    check("wrap_addr", last_acc_addr, 32'h0);

    // random stalls and redirects
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      req_ready_en  = 1'($urandom_range(0, 1));
      core_ready_en = 1'($urandom_range(0, 1));
      rsp_delay     = $urandom_range(0, 3);
      pc_src_k      = ($urandom_range(0, 3) == 0);
      pc_target_k   = $urandom() & 32'hFFFF_FFFC;
    end
    req_ready_en = 1'b1; core_ready_en = 1'b1; pc_src_k = 1'b0;
    h = n_hs; wait_hs(h + 2);

    // asynchronous reset while waiting for a response
    rsp_delay = 3;
    pc_src_k = 1'b1; pc_target_k = 32'h40;
    h = n_hs; wait_hs(h + 1); pc_src_k = 1'b0;
    wait_pending();
    check("pc_before_rst", pc, 32'h40);
    rst = 1'b1;
    #1;
    check("arst_pc", pc, RESET_PC);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'h0000_0013);
    check("arst_req", 32'(imem_req_valid), 32'd0);
    rsp_delay = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    a = n_acc;
    wait_valid();
    check("fresh_req_cnt", 32'(n_acc - a), 32'd1);
    check("fresh_req_addr", last_acc_addr, RESET_PC);
    check("fresh_instr", instr, 32'h0000_0013);

`ifdef FETCH_ALIGN_CHK_EN
    // misaligned taken target traps
    pc_src_k = 1'b1; pc_target_k = 32'h102;
    h = n_hs; wait_hs(h + 1); pc_src_k = 1'b0;
    repeat (10) begin
      check("fault_set", 32'(fetch_fault), 32'd1);
      check("halt_no_req", 32'(imem_req_valid), 32'd0);
      check("halt_no_valid", 32'(instr_valid), 32'd0);
      check("halt_pc", pc, halt_pc);
      @(posedge clk); #2;
    end
    rst = 1'b1;
    #1;
    check("fault_clr", 32'(fetch_fault), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_valid();
`else
    h = n_hs; wait_hs(h + 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
